// File: rtl/sdram_mem_tester.sv
// SDRAM memory tester: writes an LFSR pattern over a word window, reads it back, counts mismatches.
// Latency: first request registered on the i_start edge; one idle cycle between consecutive requests.
// Backpressure: each request is held until the i_ready pulse; a stalled request aborts after TIMEOUT cycles.
module sdram_mem_tester #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int          NUM_WORDS = 1024,
  parameter logic [31:0] SEED      = 32'h1234_5678,
  parameter int          TIMEOUT   = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_addr,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  input  logic [31:0] i_rdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_pass,
  output logic        o_timeout,
  output logic [15:0] o_err_cnt,
  output logic [31:0] o_err_addr
);

  // Word aligned base; an all-zero seed would lock the LFSR, so it is replaced.
  localparam logic [31:0] BASE      = {ADDR_BASE[31:2], 2'b00};
  localparam logic [31:0] SEED_EFF  = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [21:0] LAST_WORD = 22'(NUM_WORDS - 1);
  localparam logic [31:0] LAST_WAIT = 32'(TIMEOUT - 1);
  localparam logic [31:0] LFSR_TAPS = 32'hA300_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_valid;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_lfsr;
  logic [21:0] r_cnt;
  logic [31:0] r_wait;
  logic [15:0] r_err_cnt;
  logic [31:0] r_err_addr;
  logic        r_timeout;

  logic        w_active;
  logic        w_start;
  logic        w_accept;
  logic        w_expire;
  logic        w_last;
  logic        w_mismatch;
  logic [31:0] w_lfsr_nxt;

  assign w_active   = (r_state == S_WRITE) || (r_state == S_READ);
  assign w_start    = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  // i_ready only counts against an outstanding request; strays in the gap cycle are dropped.
  assign w_accept   = w_active && r_valid && i_ready;
  assign w_expire   = w_active && r_valid && !i_ready && (r_wait == LAST_WAIT);
  assign w_last     = (r_cnt == LAST_WORD);
  assign w_mismatch = (r_state == S_READ) && (i_rdata != r_lfsr);
  assign w_lfsr_nxt = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 32'h0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode: write pass, read pass, then done; a stalled request jumps straight to done.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (i_start) w_state_nxt = S_WRITE;
      S_WRITE: begin
        if (w_expire)               w_state_nxt = S_DONE;
        else if (w_accept && w_last) w_state_nxt = S_READ;
      end
      S_READ: begin
        if (w_expire)               w_state_nxt = S_DONE;
        else if (w_accept && w_last) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Status outputs decoded from the state; pass is only meaningful once done.
  always_comb begin
    o_busy = w_active;
    o_done = (r_state == S_DONE);
    o_pass = (r_state == S_DONE) && (r_err_cnt == 16'h0) && !r_timeout;
  end

  // Request issue/hold, pattern generation, address walk and error bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_wstrb    <= 4'h0;
      r_lfsr     <= 32'h0;
      r_cnt      <= 22'h0;
      r_wait     <= 32'h0;
      r_err_cnt  <= 16'h0;
      r_err_addr <= 32'h0;
      r_timeout  <= 1'b0;
    end else if (w_start) begin
      r_valid    <= 1'b1;
      r_addr     <= BASE;
      r_wdata    <= SEED_EFF;
      r_wstrb    <= 4'hF;
      r_lfsr     <= SEED_EFF;
      r_cnt      <= 22'h0;
      r_wait     <= 32'h0;
      r_err_cnt  <= 16'h0;
      r_err_addr <= 32'h0;
      r_timeout  <= 1'b0;
    end else if (w_expire) begin
      r_valid   <= 1'b0;
      r_timeout <= 1'b1;
    end else if (w_accept) begin
      // Drop valid for one cycle so the same request is never re-issued.
      r_valid <= 1'b0;
      if (w_mismatch) begin
        if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
        if (r_err_cnt == 16'h0)    r_err_addr <= r_addr;
      end
      if (w_last) begin
        // Rewind so the read pass regenerates the same sequence from the base.
        r_lfsr <= SEED_EFF;
        r_addr <= BASE;
        r_cnt  <= 22'h0;
      end else begin
        r_lfsr <= w_lfsr_nxt;
        r_addr <= r_addr + 32'd4;
        r_cnt  <= r_cnt + 22'd1;
      end
    end else if (w_active && !r_valid) begin
      r_valid <= 1'b1;
      r_wait  <= 32'h0;
      r_wdata <= (r_state == S_WRITE) ? r_lfsr : 32'h0;
      r_wstrb <= (r_state == S_WRITE) ? 4'hF : 4'h0;
    end else if (w_active && r_valid) begin
      r_wait <= r_wait + 32'd1;
    end
  end

  assign o_valid    = r_valid;
  assign o_addr     = r_addr;
  assign o_wdata    = r_wdata;
  assign o_wstrb    = r_wstrb;
  assign o_timeout  = r_timeout;
  assign o_err_cnt  = r_err_cnt;
  assign o_err_addr = r_err_addr;

endmodule
